dmem_port_sched: RTL and testbench

Single-port scheduler in front of the fixed-latency data memory. It arbitrates between two requesters: port A, the cache-miss refill/load path, and port B, the LSQ store-commit path. It allows exactly one outstanding access, sequences the memory's fixed pipeline latency, and returns a tagged, size-formatted response to the winner. It sits between the cache/LSQ and the data memory in the memory hierarchy.

---
 rtl/dmem_port_sched.sv | 187 ++++++++++++++++++
 tb/tb_dmem_port_sched.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_port_sched.sv
`default_nettype none
// ============================================================================
// Module      : dmem_port_sched
// Description : Round-robin single-outstanding scheduler between the refill
//               (A) and store-commit (B) ports and the fixed-latency dmem.
// Revision    : 1.0  initial release
// ============================================================================
module dmem_port_sched #(
    parameter int MEM_LATENCY = 10,
    parameter int MEM_BYTES   = 1024
) (
    input  logic        clk,
    input  logic        rstn,

    input  logic        a_valid,
    output logic        a_ready,
    input  logic        a_we,
    input  logic        a_size,
    input  logic [31:0] a_addr,
    input  logic [31:0] a_wdata,
    input  logic [31:0] a_pc,

    input  logic        b_valid,
    output logic        b_ready,
    input  logic        b_we,
    input  logic        b_size,
    input  logic [31:0] b_addr,
    input  logic [31:0] b_wdata,
    input  logic [31:0] b_pc,

    output logic        mem_req,
    output logic        mem_we,
    output logic        mem_size,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [31:0] mem_pc,
    input  logic [31:0] mem_rdata,

    input  logic        flush,

    output logic        resp_valid,
    output logic        resp_id,
    output logic [31:0] resp_rdata,
    output logic [31:0] resp_pc,
    output logic        resp_err,
    output logic        busy
);

    localparam int                CNT_W       = $clog2(MEM_LATENCY + 1);
    localparam logic [CNT_W-1:0]  c_CNT_LOAD  = CNT_W'(MEM_LATENCY);
    localparam logic [31:0]       c_HALF_LAST = 32'(MEM_BYTES - 2);
    localparam logic [31:0]       c_BYTE_LAST = 32'(MEM_BYTES - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t           r_state;
    state_t           w_stateNext;
    logic [CNT_W-1:0] r_cnt;
    logic             r_lastGrant;
    logic             r_cancel;
    logic             r_err;
    logic             r_id;
    logic             r_we;
    logic             r_size;
    logic [31:0]      r_addr;
    logic [31:0]      r_wdata;
    logic [31:0]      r_pc;
    logic [31:0]      r_rdata;

    logic             w_accept;
    logic             w_grantB;
    logic             w_selWe;
    logic             w_selSize;
    logic [31:0]      w_selAddr;
    logic [31:0]      w_selWdata;
    logic [31:0]      w_selPc;
    logic             w_outOfRange;
    logic [31:0]      w_loadData;
    logic             w_unusedRdata;

    // Upper read-data half never reaches the requester (halfword/byte only).
    assign w_unusedRdata = ^mem_rdata[31:16];

    // Request selection: on a tie the port that did not win last time goes.
    always_comb begin
        w_grantB   = b_valid && (!a_valid || !r_lastGrant);
        w_accept   = (r_state == IDLE) && (a_valid || b_valid);
        w_selWe    = w_grantB ? b_we    : a_we;
        w_selSize  = w_grantB ? b_size  : a_size;
        w_selAddr  = w_grantB ? b_addr  : a_addr;
        w_selWdata = w_grantB ? b_wdata : a_wdata;
        w_selPc    = w_grantB ? b_pc    : a_pc;
        w_outOfRange = w_selSize ? (w_selAddr > c_BYTE_LAST)
                                 : (w_selAddr > c_HALF_LAST);
        w_loadData = r_size ? {24'b0, mem_rdata[7:0]} : {16'b0, mem_rdata[15:0]};
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_stateNext;
        end
    end

    // A rejected address still passes through ISSUE for one cycle, with the
    // memory strobe suppressed, so the error response lands one cycle later.
    always_comb begin
        w_stateNext = r_state;
        case (r_state)
            IDLE:  if (w_accept) w_stateNext = ISSUE;
            ISSUE: w_stateNext = r_err ? RESP : WAIT;
            WAIT:  if (r_cnt == '0) w_stateNext = RESP;
            RESP:  w_stateNext = IDLE;
            default: w_stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_cnt       <= '0;
            r_lastGrant <= 1'b1;
            r_cancel    <= 1'b0;
            r_err       <= 1'b0;
            r_id        <= 1'b0;
            r_we        <= 1'b0;
            r_size      <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_pc        <= '0;
            r_rdata     <= '0;
        end else begin
            if (w_accept) begin
                r_lastGrant <= w_grantB;
                r_id        <= w_grantB;
                r_we        <= w_selWe;
                r_size      <= w_selSize;
                r_addr      <= w_selAddr;
                r_wdata     <= w_selWdata;
                r_pc        <= w_selPc;
                r_err       <= w_outOfRange;
                r_rdata     <= '0;
            end

            if (r_state == ISSUE && !r_err) begin
                r_cnt <= c_CNT_LOAD;
            end else if (r_state == WAIT) begin
                if (r_cnt != '0) begin
                    r_cnt <= r_cnt - 1'b1;
                end else if (!r_we) begin
                    r_rdata <= w_loadData;
                end
            end

            // Flush only silences the response; the access itself completes.
            if (r_state == RESP) begin
                r_cancel <= 1'b0;
            end else if (r_state != IDLE && flush) begin
                r_cancel <= 1'b1;
            end
        end
    end

    assign a_ready    = (r_state == IDLE);
    assign b_ready    = (r_state == IDLE);
    assign busy       = (r_state != IDLE);

    assign mem_req    = (r_state == ISSUE) && !r_err;
    assign mem_we     = r_we;
    assign mem_size   = r_size;
    assign mem_addr   = r_addr;
    assign mem_wdata  = r_wdata;
    assign mem_pc     = r_pc;

    assign resp_valid = (r_state == RESP) && !r_cancel;
    assign resp_id    = r_id;
    assign resp_rdata = r_rdata;
    assign resp_pc    = r_pc;
    assign resp_err   = r_err;

endmodule
`default_nettype wire

// File: tb/tb_dmem_port_sched.sv
`default_nettype none
// ============================================================================
// Module      : tb_dmem_port_sched
// Description : Directed self-checking bench for dmem_port_sched.
// Revision    : 1.0  initial release
// ============================================================================
module tb_dmem_port_sched;

    logic        clk;
    logic        rstn;
    logic        a_valid, a_ready, a_we, a_size;
    logic [31:0] a_addr, a_wdata, a_pc;
    logic        b_valid, b_ready, b_we, b_size;
    logic [31:0] b_addr, b_wdata, b_pc;
    logic        mem_req, mem_we, mem_size;
    logic [31:0] mem_addr, mem_wdata, mem_pc, mem_rdata;
    logic        flush;
    logic        resp_valid, resp_id, resp_err, busy;
    logic [31:0] resp_rdata, resp_pc;

    int errors = 0;
    int checks = 0;

    dmem_port_sched #(.MEM_LATENCY(10), .MEM_BYTES(1024)) dut (
        .clk(clk), .rstn(rstn),
        .a_valid(a_valid), .a_ready(a_ready), .a_we(a_we), .a_size(a_size),
        .a_addr(a_addr), .a_wdata(a_wdata), .a_pc(a_pc),
        .b_valid(b_valid), .b_ready(b_ready), .b_we(b_we), .b_size(b_size),
        .b_addr(b_addr), .b_wdata(b_wdata), .b_pc(b_pc),
        .mem_req(mem_req), .mem_we(mem_we), .mem_size(mem_size),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_pc(mem_pc),
        .mem_rdata(mem_rdata), .flush(flush),
        .resp_valid(resp_valid), .resp_id(resp_id), .resp_rdata(resp_rdata),
        .resp_pc(resp_pc), .resp_err(resp_err), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic do_reset();
        rstn = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #3 rstn = 1'b1;
    endtask

    // Present one request on the chosen port for a single accepting edge.
    task automatic issue(input logic port, input logic we, input logic sz,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [31:0] pc);
        if (!port) begin
            a_we = we; a_size = sz; a_addr = addr; a_wdata = wdata; a_pc = pc;
            a_valid = 1'b1;
        end else begin
            b_we = we; b_size = sz; b_addr = addr; b_wdata = wdata; b_pc = pc;
            b_valid = 1'b1;
        end
        @(posedge clk);
        #1;
        a_valid = 1'b0;
        b_valid = 1'b0;
    endtask

    // Records what happens from the accept edge (e=0) through nEdges edges.
    task automatic observe(input int nEdges, input int flushAt,
                           output int reqCnt, output int respCnt,
                           output int respEdge, output int idleEdge,
                           output logic [31:0] rd, output logic id,
                           output logic [31:0] pc, output logic err);
        reqCnt = 0; respCnt = 0; respEdge = -1; idleEdge = -1;
        rd = '0; id = 1'b0; pc = '0; err = 1'b0;
        for (int e = 0; e <= nEdges; e++) begin
            if (e > 0) begin
                @(posedge clk);
                #1;
            end
            flush = (e == flushAt);
            if (mem_req) reqCnt++;
            if (resp_valid) begin
                respCnt++;
                if (respEdge < 0) begin
                    respEdge = e; rd = resp_rdata; id = resp_id;
                    pc = resp_pc; err = resp_err;
                end
            end
            if (e > 0 && a_ready && idleEdge < 0) idleEdge = e;
        end
        flush = 1'b0;
    endtask

    task automatic test_reset();
        #2;
        checks++;
        if (a_ready !== 1'b1 || b_ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_ready: a_ready=%b b_ready=%b busy=%b want 1 1 0", a_ready, b_ready, busy);
        end
        checks++;
        if (mem_req !== 1'b0 || resp_valid !== 1'b0 || resp_err !== 1'b0 ||
            resp_rdata !== 32'h0 || resp_pc !== 32'h0 || mem_addr !== 32'h0) begin
            errors++;
            $display("FAIL reset_outputs: req=%b rv=%b err=%b rdata=%h pc=%h addr=%h want all 0",
                     mem_req, resp_valid, resp_err, resp_rdata, resp_pc, mem_addr);
        end
        do_reset();
    endtask

    task automatic test_load_half();
        int rq, rc, re, ie; logic [31:0] rd, pc; logic id, er;
        mem_rdata = 32'hDEADBEEF;
        issue(1'b0, 1'b0, 1'b0, 32'h10, 32'h0, 32'h100);
        checks++;
        if (mem_req !== 1'b1 || mem_addr !== 32'h10 || mem_we !== 1'b0 || mem_pc !== 32'h100) begin
            errors++;
            $display("FAIL load_issue: req=%b addr=%h we=%b pc=%h want 1 10 0 100", mem_req, mem_addr, mem_we, mem_pc);
        end
        observe(20, -1, rq, rc, re, ie, rd, id, pc, er);
        checks++;
        if (rq !== 1 || rc !== 1 || re !== 12 || ie !== 13) begin
            errors++;
            $display("FAIL load_timing: req=%0d resp=%0d respEdge=%0d idleEdge=%0d want 1 1 12 13", rq, rc, re, ie);
        end
        checks++;
        if (rd !== 32'h0000BEEF || id !== 1'b0 || pc !== 32'h100 || er !== 1'b0) begin
            errors++;
            $display("FAIL load_resp: rdata=%h id=%b pc=%h err=%b want 0000beef 0 100 0", rd, id, pc, er);
        end
    endtask

    task automatic test_load_byte();
        int rq, rc, re, ie; logic [31:0] rd, pc; logic id, er;
        mem_rdata = 32'h12345678;
        issue(1'b0, 1'b0, 1'b1, 32'h21, 32'h0, 32'h104);
        observe(20, -1, rq, rc, re, ie, rd, id, pc, er);
        checks++;
        if (rd !== 32'h00000078 || re !== 12 || pc !== 32'h104) begin
            errors++;
            $display("FAIL byte_load: rdata=%h respEdge=%0d pc=%h want 00000078 12 104", rd, re, pc);
        end
    endtask

    task automatic test_bounds();
        int rq, rc, re, ie; logic [31:0] rd, pc; logic id, er;
        mem_rdata = 32'hFFFFFFFF;
        issue(1'b1, 1'b1, 1'b1, 32'h3FF, 32'h000000A5, 32'h200);
        checks++;
        if (mem_req !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 32'h3FF || mem_wdata !== 32'hA5) begin
            errors++;
            $display("FAIL store_issue: req=%b we=%b addr=%h wdata=%h want 1 1 3ff a5", mem_req, mem_we, mem_addr, mem_wdata);
        end
        observe(20, -1, rq, rc, re, ie, rd, id, pc, er);
        checks++;
        if (rq !== 1 || re !== 12 || er !== 1'b0 || rd !== 32'h0 || id !== 1'b1 || pc !== 32'h200) begin
            errors++;
            $display("FAIL store_byte_3ff: req=%0d respEdge=%0d err=%b rdata=%h id=%b pc=%h want 1 12 0 0 1 200",
                     rq, re, er, rd, id, pc);
        end
        issue(1'b1, 1'b0, 1'b0, 32'h3FF, 32'h0, 32'h204);
        observe(20, -1, rq, rc, re, ie, rd, id, pc, er);
        checks++;
        if (rq !== 0 || rc !== 1 || re !== 1 || ie !== 2) begin
            errors++;
            $display("FAIL half_3ff_timing: req=%0d resp=%0d respEdge=%0d idleEdge=%0d want 0 1 1 2", rq, rc, re, ie);
        end
        checks++;
        if (er !== 1'b1 || rd !== 32'h0 || id !== 1'b1 || pc !== 32'h204) begin
            errors++;
            $display("FAIL half_3ff_resp: err=%b rdata=%h id=%b pc=%h want 1 0 1 204", er, rd, id, pc);
        end
        mem_rdata = 32'h0000ABCD;
        issue(1'b1, 1'b0, 1'b0, 32'h3FE, 32'h0, 32'h208);
        observe(20, -1, rq, rc, re, ie, rd, id, pc, er);
        checks++;
        if (rq !== 1 || er !== 1'b0 || re !== 12 || rd !== 32'h0000ABCD) begin
            errors++;
            $display("FAIL half_3fe: req=%0d err=%b respEdge=%0d rdata=%h want 1 0 12 0000abcd", rq, er, re, rd);
        end
    endtask

    task automatic test_back_to_back();
        int accEdge[8]; int nAcc; logic respIds[8]; logic [31:0] respPcs[8];
        int nResp; int readyViol; logic prevBusy;
        nAcc = 0; nResp = 0; readyViol = 0; prevBusy = 1'b0;
        mem_rdata = 32'h00001111;
        a_we = 1'b0; a_size = 1'b0; a_addr = 32'h20; a_pc = 32'hA0;
        b_we = 1'b0; b_size = 1'b0; b_addr = 32'h30; b_pc = 32'hB0;
        rstn = 1'b0;
        a_valid = 1'b1;
        b_valid = 1'b1;
        @(posedge clk);
        #3 rstn = 1'b1;
        for (int e = 1; e <= 58; e++) begin
            @(posedge clk);
            #1;
            if (busy && !prevBusy && nAcc < 8) begin
                accEdge[nAcc] = e;
                nAcc++;
            end
            if (busy && (a_ready || b_ready)) readyViol++;
            if (resp_valid && nResp < 8) begin
                respIds[nResp] = resp_id;
                respPcs[nResp] = resp_pc;
                nResp++;
            end
            prevBusy = busy;
        end
        a_valid = 1'b0;
        b_valid = 1'b0;
        checks++;
        if (nAcc !== 5 || readyViol !== 0) begin
            errors++;
            $display("FAIL rr_accepts: accepts=%0d readyWhileBusy=%0d want 5 0", nAcc, readyViol);
        end
        for (int i = 1; i < 5 && i < nAcc; i++) begin
            checks++;
            if (accEdge[i] - accEdge[i-1] !== 14) begin
                errors++;
                $display("FAIL rr_spacing[%0d]: gap=%0d want 14", i, accEdge[i] - accEdge[i-1]);
            end
        end
        checks++;
        if (nResp !== 4) begin
            errors++;
            $display("FAIL rr_resp_count: got %0d want 4", nResp);
        end
        for (int i = 0; i < 4 && i < nResp; i++) begin
            checks++;
            if (respIds[i] !== i[0] || respPcs[i] !== (i[0] ? 32'hB0 : 32'hA0)) begin
                errors++;
                $display("FAIL rr_order[%0d]: id=%b pc=%h want %b %h", i, respIds[i], respPcs[i],
                         i[0], (i[0] ? 32'hB0 : 32'hA0));
            end
        end
        for (int i = 0; i < 20 && busy; i++) begin
            @(posedge clk);
            #1;
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL rr_drain: busy=%b want 0", busy);
        end
    endtask

    task automatic test_flush();
        int rq, rc, re, ie; logic [31:0] rd, pc; logic id, er;
        mem_rdata = 32'hCAFEF00D;
        issue(1'b0, 1'b1, 1'b0, 32'h40, 32'h1234, 32'h300);
        observe(20, 5, rq, rc, re, ie, rd, id, pc, er);
        checks++;
        if (rq !== 1 || rc !== 0 || ie !== 13) begin
            errors++;
            $display("FAIL flush_wait: req=%0d resp=%0d idleEdge=%0d want 1 0 13", rq, rc, ie);
        end
        flush = 1'b1;
        issue(1'b0, 1'b0, 1'b0, 32'h50, 32'h0, 32'h304);
        observe(20, -1, rq, rc, re, ie, rd, id, pc, er);
        checks++;
        if (rq !== 1 || rc !== 1 || re !== 12 || rd !== 32'h0000F00D || pc !== 32'h304) begin
            errors++;
            $display("FAIL flush_after: req=%0d resp=%0d respEdge=%0d rdata=%h pc=%h want 1 1 12 0000f00d 304",
                     rq, rc, re, rd, pc);
        end
    endtask

    task automatic test_reset_mid();
        int rq, rc, re, ie; logic [31:0] rd, pc; logic id, er;
        mem_rdata = 32'h55667788;
        issue(1'b0, 1'b0, 1'b0, 32'h60, 32'h0, 32'h400);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
        end
        #2 rstn = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || mem_req !== 1'b0 || resp_valid !== 1'b0 || resp_pc !== 32'h0 ||
            mem_addr !== 32'h0 || a_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid: busy=%b req=%b rv=%b pc=%h addr=%h a_ready=%b want 0 0 0 0 0 1",
                     busy, mem_req, resp_valid, resp_pc, mem_addr, a_ready);
        end
        @(posedge clk);
        #3 rstn = 1'b1;
        observe(20, -1, rq, rc, re, ie, rd, id, pc, er);
        checks++;
        if (rc !== 0 || rq !== 0 || a_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid_after: resp=%0d req=%0d a_ready=%b want 0 0 1", rc, rq, a_ready);
        end
    endtask

    initial begin
        rstn = 1'b0; flush = 1'b0; mem_rdata = '0;
        a_valid = 1'b0; a_we = 1'b0; a_size = 1'b0; a_addr = '0; a_wdata = '0; a_pc = '0;
        b_valid = 1'b0; b_we = 1'b0; b_size = 1'b0; b_addr = '0; b_wdata = '0; b_pc = '0;
        test_reset();
        test_load_half();
        test_load_byte();
        test_bounds();
        test_back_to_back();
        test_flush();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
